// File: rtl/ram_bank.sv
// ram_bank: parametrised synchronous single-port RAM with a registered read
// port and a hardware clear sequencer that zeroes every word after reset or
// on a clear pulse. Requests arriving during the sweep are discarded and
// flagged one cycle later on 'dropped'.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset (starts a clear sweep)
//   memoryEN  access request
//   rw        1 = read, 0 = write
//   adress    word address
//   in_word   write data
//   clear     single-cycle pulse restarting the zeroing sweep
//   out_word  registered read data (zero when not valid)
//   out_valid out_word holds read data this cycle
//   busy      clear sweep in progress
//   dropped   request sampled last cycle was discarded
module ram_bank #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memoryEN,
  input  logic              rw,
  input  logic [ADDR_W-1:0] adress,
  input  logic [WIDTH-1:0]  in_word,
  input  logic              clear,
  output logic [WIDTH-1:0]  out_word,
  output logic              out_valid,
  output logic              busy,
  output logic              dropped
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic {
    CLEAR,
    IDLE
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic [WIDTH-1:0]  mem [DEPTH];

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [WIDTH-1:0]  wd;

  // Single write port shared by the sweep and user writes; reset and a
  // clear pulse suppress any write in that cycle.
  always_comb begin
    we = 1'b0;
    wa = adress;
    wd = in_word;
    if (!rst && !clear) begin
      if (state == CLEAR) begin
        we = 1'b1;
        wa = clr_addr;
        wd = '0;
      end else if (memoryEN && !rw) begin
        we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wa] <= wd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      clr_addr  <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b1;
      dropped   <= 1'b0;
    end else begin
      dropped   <= memoryEN && (clear || state == CLEAR);
      out_word  <= '0;
      out_valid <= 1'b0;
      if (clear) begin
        state    <= CLEAR;
        clr_addr <= '0;
        busy     <= 1'b1;
      end else begin
        case (state)
          CLEAR: begin
            // Last word written this cycle; hold clr_addr rather than wrap.
            if (clr_addr == '1) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              clr_addr <= clr_addr + 1'b1;
            end
          end
          IDLE: begin
            if (memoryEN && rw) begin
              out_word  <= mem[adress];
              out_valid <= 1'b1;
            end
          end
          default: state <= CLEAR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_bank.sv
module tb_ram_bank;

  logic       clk = 1'b0;
  logic       rst;
  logic       memoryEN;
  logic       rw;
  logic [3:0] adress;
  logic [7:0] in_word;
  logic       clear;
  logic [7:0] out_word;
  logic       out_valid;
  logic       busy;
  logic       dropped;

  ram_bank #(.WIDTH(8), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .memoryEN(memoryEN), .rw(rw), .adress(adress),
    .in_word(in_word), .clear(clear), .out_word(out_word),
    .out_valid(out_valid), .busy(busy), .dropped(dropped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [7:0] data;
  } rd_exp_t;

  rd_exp_t rd_q[$];
  int      drop_q[$];
  int      cyc = 0;
  int      checks = 0;
  int      errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a read result
  // or a dropped pulse, and checks the cycle it arrived on.
  always @(negedge clk) begin
    if (out_valid) begin
      chk("valid_implies_not_busy", busy, 0);
      if (rd_q.size() == 0) begin
        chk("unexpected_out_valid", 1, 0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        chk("read_cycle", cyc, e.cyc);
        chk("read_data", out_word, e.data);
      end
    end
    if (dropped) begin
      if (drop_q.size() == 0) begin
        chk("unexpected_dropped", 1, 0);
      end else begin
        chk("dropped_cycle", cyc, drop_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    memoryEN = 1'b0;
    clear    = 1'b0;
    step();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp);
    memoryEN = 1'b1; rw = 1'b1; adress = a;
    rd_q.push_back('{cyc + 1, exp});
    step();
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    memoryEN = 1'b1; rw = 1'b0; adress = a; in_word = d;
    step();
  endtask

  // Expects busy high for exactly 16 sampled cycles starting now, then low.
  task automatic check_sweep(input string name);
    for (int i = 0; i < 16; i++) begin
      chk(name, busy, 1);
      memoryEN = 1'b0;
      step();
    end
    chk({name, "_done"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; memoryEN = 1'b0; rw = 1'b0; adress = '0; in_word = '0;
    clear = 1'b0;
    step();
    rst = 1'b0;
    chk("reset_busy", busy, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_word", out_word, 0);
    chk("reset_dropped", dropped, 0);

    // Sweep after reset; read at sweep cycle 5 and write at cycle 7 are dropped.
    for (int i = 0; i < 16; i++) begin
      chk("sweep_busy", busy, 1);
      memoryEN = 1'b0;
      if (i == 5) begin
        memoryEN = 1'b1; rw = 1'b1; adress = 4'd2;
        drop_q.push_back(cyc + 1);
      end
      if (i == 7) begin
        memoryEN = 1'b1; rw = 1'b0; adress = 4'd9; in_word = 8'hFF;
        drop_q.push_back(cyc + 1);
      end
      step();
    end
    chk("sweep_busy_done", busy, 0);

    // All words zero, including addr 9 whose write was dropped.
    for (int a = 0; a < 16; a++) rd(4'(a), 8'h00);
    idle();

    wr(4'd3, 8'hA5);
    rd(4'd3, 8'hA5);
    idle();

    wr(4'd0, 8'h11);
    wr(4'd15, 8'h22);
    rd(4'd15, 8'h22);
    rd(4'd0, 8'h11);
    idle();

    // Clear in IDLE together with a read: clear wins, request dropped.
    wr(4'd7, 8'h3C);
    rd(4'd7, 8'h3C);
    memoryEN = 1'b1; rw = 1'b1; adress = 4'd7; clear = 1'b1;
    drop_q.push_back(cyc + 1);
    step();
    clear = 1'b0; memoryEN = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("first_clear_busy", busy, 1);
      step();
    end
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_sweep("restart_busy");
    rd(4'd7, 8'h00);
    rd(4'd3, 8'h00);
    idle();

    // Reset during a read: no result, busy immediately.
    wr(4'd5, 8'h77);
    memoryEN = 1'b1; rw = 1'b1; adress = 4'd5; rst = 1'b1;
    step();
    rst = 1'b0; memoryEN = 1'b0;
    chk("rst_mid_read_out_word", out_word, 0);
    chk("rst_mid_read_out_valid", out_valid, 0);
    check_sweep("rst_mid_read_busy");
    rd(4'd5, 8'h00);
    idle();
    idle();

    chk("read_queue_empty", rd_q.size(), 0);
    chk("drop_queue_empty", drop_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
